// File: rtl/freq_lock_pkg.sv
// Shared constants for the frequency-locking loop controller.
package freq_lock_pkg;
  localparam int THETA_W = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_ACQ   = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  localparam logic [23:0] FW_MIN_DEF     = 24'h400000;
  localparam logic [23:0] FW_MAX_DEF     = 24'h480000;
  localparam int          SWEEP_STEP_DEF = 16;
endpackage

// File: rtl/freq_lock_pi.sv
// PI datapath: saturating integrator plus shifted proportional term, clamped to the DDS range.
module freq_lock_pi
  import freq_lock_pkg::*;
#(
  parameter int              FW_W    = 24,
  parameter logic [FW_W-1:0] FW_MIN  = FW_MIN_DEF,
  parameter logic [FW_W-1:0] FW_MAX  = FW_MAX_DEF,
  parameter int              KI_FRAC = 4,
  parameter int              KP_SHL  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_load,
  input  logic                      i_en,
  input  logic [FW_W-1:0]           i_fw,
  input  logic signed [THETA_W-1:0] i_theta,
  output logic [FW_W-1:0]           o_fw_next
);
  localparam int IW = FW_W + KI_FRAC + 1;
  localparam int PW = FW_W + 2;

  localparam logic signed [IW-1:0] I_MIN = $signed({1'b0, FW_MIN, {KI_FRAC{1'b0}}});
  localparam logic signed [IW-1:0] I_MAX = $signed({1'b0, FW_MAX, {KI_FRAC{1'b1}}});
  localparam logic signed [PW-1:0] P_MIN = $signed({2'b00, FW_MIN});
  localparam logic signed [PW-1:0] P_MAX = $signed({2'b00, FW_MAX});

  logic signed [IW-1:0] r_i;
  logic signed [IW-1:0] w_sum;
  logic signed [IW-1:0] w_i_next;
  logic signed [PW-1:0] w_int;
  logic signed [PW-1:0] w_prop;
  logic signed [PW-1:0] w_pi;

  always_comb begin
    w_sum = r_i + {{(IW-THETA_W){i_theta[THETA_W-1]}}, i_theta};
    if (w_sum < I_MIN)      w_i_next = I_MIN;
    else if (w_sum > I_MAX) w_i_next = I_MAX;
    else                    w_i_next = w_sum;

    // Proportional path uses the updated integrator, so fw responds within the same sample.
    w_int  = {w_i_next[IW-1], w_i_next[IW-1:KI_FRAC]};
    w_prop = {{(PW-THETA_W-KP_SHL){i_theta[THETA_W-1]}}, i_theta, {KP_SHL{1'b0}}};
    w_pi   = w_int + w_prop;
    if (w_pi < P_MIN)      o_fw_next = FW_MIN;
    else if (w_pi > P_MAX) o_fw_next = FW_MAX;
    else                   o_fw_next = w_pi[FW_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) r_i <= I_MIN;
    else if (i_load)       r_i <= $signed({1'b0, i_fw, {KI_FRAC{1'b0}}});
    else if (i_en)         r_i <= w_i_next;
  end
endmodule

// File: rtl/freq_lock_ctrl.sv
// Sweep-then-PI frequency lock controller driving the DDS tuning word from filtered phase error.
module freq_lock_ctrl
  import freq_lock_pkg::*;
#(
  parameter int              FW_W       = 24,
  parameter logic [FW_W-1:0] FW_MIN     = FW_MIN_DEF,
  parameter logic [FW_W-1:0] FW_MAX     = FW_MAX_DEF,
  parameter int              SWEEP_STEP = SWEEP_STEP_DEF,
  parameter int              KI_FRAC    = 4,
  parameter int              KP_SHL     = 2,
  parameter int              LOCK_THR   = 8,
  parameter int              LOCK_CNT   = 600,
  parameter int              UNLOCK_CNT = 60
) (
  input  logic                      clk60kHz,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [THETA_W-1:0] theta,
  output logic [FW_W-1:0]           fw,
  output logic                      locked,
  output logic [1:0]                state,
  output logic                      sweep_wrap
);
  localparam int CW = $clog2(((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT) + 1);

  logic [1:0]      r_state, w_state_n;
  logic [FW_W-1:0] r_fw, w_fw_n;
  logic            r_locked, r_wrap, w_wrap_n;
  logic [CW-1:0]   r_in_cnt, w_in_n, r_out_cnt, w_out_n;
  logic            w_pi_clr, w_pi_load, w_pi_en;
  logic [FW_W-1:0] w_pi_fw;
  logic [THETA_W:0] w_theta_x, w_mag;
  logic            w_in_win;
  logic [FW_W:0]   w_step;
  logic            w_over;

  freq_lock_pi #(
    .FW_W(FW_W), .FW_MIN(FW_MIN), .FW_MAX(FW_MAX), .KI_FRAC(KI_FRAC), .KP_SHL(KP_SHL)
  ) u_pi (
    .i_clk(clk60kHz), .i_rst_n(rst_n), .i_clr(w_pi_clr), .i_load(w_pi_load), .i_en(w_pi_en),
    .i_fw(r_fw), .i_theta(theta), .o_fw_next(w_pi_fw)
  );

  // Eleven bits so that -512 yields a true magnitude of 512.
  assign w_theta_x = {theta[THETA_W-1], theta};
  assign w_mag     = theta[THETA_W-1] ? (~w_theta_x + 1'b1) : w_theta_x;
  assign w_in_win  = (w_mag <= (THETA_W+1)'(LOCK_THR));
  assign w_step    = {1'b0, r_fw} + (FW_W+1)'(SWEEP_STEP);
  assign w_over    = (w_step > {1'b0, FW_MAX});

  always_comb begin
    w_state_n = r_state;
    w_fw_n    = r_fw;
    w_wrap_n  = 1'b0;
    w_in_n    = '0;
    w_out_n   = '0;
    w_pi_clr  = 1'b0;
    w_pi_load = 1'b0;
    w_pi_en   = 1'b0;
    if (!en) begin
      w_state_n = ST_IDLE;
      w_fw_n    = FW_MIN;
      w_pi_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_SWEEP;
          w_fw_n    = FW_MIN;
          w_pi_clr  = 1'b1;
        end
        ST_SWEEP: begin
          if (w_in_win) begin
            w_state_n = ST_ACQ;
            w_pi_load = 1'b1;
            w_in_n    = CW'(1);
          end else if (w_over) begin
            w_fw_n   = FW_MIN;
            w_wrap_n = 1'b1;
          end else begin
            w_fw_n = w_step[FW_W-1:0];
          end
        end
        default: begin
          w_pi_en = 1'b1;
          w_fw_n  = w_pi_fw;
          if (w_in_win) w_in_n  = (r_in_cnt == CW'(LOCK_CNT)) ? r_in_cnt : r_in_cnt + 1'b1;
          else          w_out_n = (r_out_cnt == CW'(UNLOCK_CNT)) ? r_out_cnt : r_out_cnt + 1'b1;
          if (w_out_n == CW'(UNLOCK_CNT))
            w_state_n = ST_SWEEP;
          else if (r_state == ST_ACQ && w_in_n == CW'(LOCK_CNT))
            w_state_n = ST_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk60kHz) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_fw      <= FW_MIN;
      r_locked  <= 1'b0;
      r_wrap    <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_n;
      r_fw      <= w_fw_n;
      r_locked  <= (w_state_n == ST_LOCK);
      r_wrap    <= w_wrap_n;
      r_in_cnt  <= w_in_n;
      r_out_cnt <= w_out_n;
    end
  end

  assign fw         = r_fw;
  assign locked     = r_locked;
  assign state      = r_state;
  assign sweep_wrap = r_wrap;
endmodule

// File: tb/tb_freq_lock_ctrl.sv
// Directed bench for freq_lock_ctrl: short vector table plus long sweep/lock/clamp sequences.
module tb_freq_lock_ctrl;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic signed [9:0] theta = '0;
  logic [23:0]       fw;
  logic              locked;
  logic [1:0]        state;
  logic              sweep_wrap;

  int checks = 0;
  int failures = 0;

  freq_lock_ctrl dut (
    .clk60kHz(clk), .rst_n(rst_n), .en(en), .theta(theta),
    .fw(fw), .locked(locked), .state(state), .sweep_wrap(sweep_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             nm;
    logic              rst_n;
    logic              en;
    logic signed [9:0] theta;
    logic [1:0]        st;
    logic [23:0]       fw;
    logic              lk;
    logic              wr;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [23:0] f,
                         input logic lk, input logic wr);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".fw"}, 32'(fw), 32'(f));
    chk({nm, ".locked"}, 32'(locked), 32'(lk));
    chk({nm, ".wrap"}, 32'(sweep_wrap), 32'(wr));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst_n = vecs[i].rst_n;
      en    = vecs[i].en;
      theta = vecs[i].theta;
      tick();
      chk_all(vecs[i].nm, vecs[i].st, vecs[i].fw, vecs[i].lk, vecs[i].wr);
    end
  endtask

  initial begin
    int bad;
    vecs[0]  = '{"rst0",      1'b0, 1'b1, 10'sd100,  2'd0, 24'h400000, 1'b0, 1'b0};
    vecs[1]  = '{"rst1",      1'b0, 1'b1, 10'sd100,  2'd0, 24'h400000, 1'b0, 1'b0};
    vecs[2]  = '{"rst2",      1'b0, 1'b1, 10'sd100,  2'd0, 24'h400000, 1'b0, 1'b0};
    vecs[3]  = '{"rel_enter", 1'b1, 1'b1, 10'sd100,  2'd1, 24'h400000, 1'b0, 1'b0};
    vecs[4]  = '{"rel_step1", 1'b1, 1'b1, 10'sd100,  2'd1, 24'h400010, 1'b0, 1'b0};
    vecs[5]  = '{"rel_step2", 1'b1, 1'b1, 10'sd100,  2'd1, 24'h400020, 1'b0, 1'b0};
    vecs[6]  = '{"endrop",    1'b1, 1'b0, 10'sd0,    2'd0, 24'h400000, 1'b0, 1'b0};
    vecs[7]  = '{"reen",      1'b1, 1'b1, 10'sd100,  2'd1, 24'h400000, 1'b0, 1'b0};
    vecs[8]  = '{"reen_s1",   1'b1, 1'b1, 10'sd100,  2'd1, 24'h400010, 1'b0, 1'b0};
    vecs[9]  = '{"reen_s2",   1'b1, 1'b1, 10'sd100,  2'd1, 24'h400020, 1'b0, 1'b0};
    vecs[10] = '{"midrst",    1'b0, 1'b1, 10'sd100,  2'd0, 24'h400000, 1'b0, 1'b0};
    vecs[11] = '{"post_rst",  1'b1, 1'b1, -10'sd512, 2'd1, 24'h400000, 1'b0, 1'b0};
    vecs[12] = '{"thr_out9",  1'b1, 1'b1, 10'sd9,    2'd1, 24'h400010, 1'b0, 1'b0};
    vecs[13] = '{"thr_in_m8", 1'b1, 1'b1, -10'sd8,   2'd2, 24'h400010, 1'b0, 1'b0};
    vecs[14] = '{"pi_clampl", 1'b1, 1'b1, -10'sd8,   2'd2, 24'h400000, 1'b0, 1'b0};
    vecs[15] = '{"acq_drop",  1'b1, 1'b0, -10'sd8,   2'd0, 24'h400000, 1'b0, 1'b0};

    @(negedge clk);
    run_vecs(0, 5);

    // Sweep up to FW_MAX exactly, then the wrapping step.
    bad = 0;
    for (int i = 0; i < 32766; i++) begin
      tick();
      if (sweep_wrap !== 1'b0 || state !== 2'd1) bad++;
    end
    chk("sweep_nowrap_run", 32'(bad), 32'd0);
    chk_all("sweep_at_max", 2'd1, 24'h480000, 1'b0, 1'b0);
    tick();
    chk_all("sweep_wrap", 2'd1, 24'h400000, 1'b0, 1'b1);
    tick();
    chk_all("sweep_after_wrap", 2'd1, 24'h400010, 1'b0, 1'b0);

    // Acquire with theta=3, then lock on the 600th in-window sample.
    theta = 10'sd3;
    tick();
    chk_all("acq_entry", 2'd2, 24'h400010, 1'b0, 1'b0);
    tick();
    chk_all("acq_pi1", 2'd2, 24'h40001C, 1'b0, 1'b0);
    for (int i = 0; i < 597; i++) tick();
    chk("acq_599.state", 32'(state), 32'd2);
    tick();
    chk_all("lock_600", 2'd3, 24'h40008C, 1'b1, 1'b0);

    // Loss of lock: 59 out, 1 in, 60 out.
    theta = 10'sd50;
    for (int i = 0; i < 59; i++) tick();
    chk("lol_59.state", 32'(state), 32'd3);
    theta = 10'sd0;
    tick();
    chk("lol_in.state", 32'(state), 32'd3);
    theta = 10'sd50;
    for (int i = 0; i < 59; i++) tick();
    chk("lol_run2_59.locked", 32'(locked), 32'd1);
    tick();
    chk_all("lol_abandon", 2'd1, 24'h4002BC, 1'b0, 1'b0);
    tick();
    chk_all("lol_resume", 2'd1, 24'h4002CC, 1'b0, 1'b0);

    // Sweep on to FW_MAX-4, acquire there and push theta=+511.
    for (int i = 0; i < 32723; i++) tick();
    chk_all("sweep_max_m4", 2'd1, 24'h47FFFC, 1'b0, 1'b0);
    theta = 10'sd0;
    tick();
    chk_all("acq_hi_entry", 2'd2, 24'h47FFFC, 1'b0, 1'b0);
    theta = 10'sd511;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("clamp_hi%0d", i), 2'd2, 24'h480000, 1'b0, 1'b0);
    end

    // Reacquire just above FW_MIN and push theta=-512.
    en = 1'b0;
    tick();
    chk_all("hi_endrop", 2'd0, 24'h400000, 1'b0, 1'b0);
    en = 1'b1; theta = 10'sd100;
    tick();
    tick();
    chk_all("lo_sweep", 2'd1, 24'h400010, 1'b0, 1'b0);
    theta = 10'sd0;
    tick();
    chk_all("acq_lo_entry", 2'd2, 24'h400010, 1'b0, 1'b0);
    theta = -10'sd512;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("clamp_lo%0d", i), 2'd2, 24'h400000, 1'b0, 1'b0);
    end

    // Lock at FW_MIN, then enable drop and the remaining table rows.
    theta = 10'sd0;
    for (int i = 0; i < 599; i++) tick();
    chk("lo_acq_599.state", 32'(state), 32'd2);
    tick();
    chk_all("lo_lock_600", 2'd3, 24'h400000, 1'b1, 1'b0);
    run_vecs(6, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
